mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared multiplier. Accepts multiply requests from `NUM_PORTS` requesters, grants one at a time, and drives `mult_mux` select/active/start. Holds the grant until the multiplier reports `done_i`, captures the result, returns a per-port completion pulse, and rotates priority. Sits between the layer engines and the `mult_mux`/multiplier pair.

---
 rtl/mult_pkg.sv | 13 +
 rtl/rr_pick.sv | 27 ++
 rtl/mult_arbiter.sv | 120 ++++++++++++
 tb/tb_mult_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and defaults for the multiplier arbiter and its helpers.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    BUSY    = 2'd2,
    RELEASE = 2'd3
  } mult_arb_state_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set bit of req at or above ptr, wrapping.
module rr_pick #(
  parameter int N = 6,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  always_comb begin
    int c;
    c     = 0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      c = int'(ptr) + i;
      if (c >= N) c = c - N;
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = W'(c);
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer for the shared multiplier.
// Optional watchdog: define MULT_ARB_TIMEOUT_EN to abort stalled BUSY phases.
//
// state   | meaning
// IDLE    | arbitrate among pending requests
// GRANT   | one-cycle start pulse to the chosen port
// BUSY    | wait for multiplier done (or watchdog expiry)
// RELEASE | completion pulse to owner, rotate pointer
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int NUM_PORTS      = 6,
  parameter int SEL_WIDTH      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  parameter int DataWidth      = 8,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_PORTS-1:0]   req_i,
  output logic [NUM_PORTS-1:0]   grant_o,
  output logic [NUM_PORTS-1:0]   done_o,
  output logic [2*DataWidth-1:0] result_o,
  output logic [SEL_WIDTH-1:0]   select_o,
  output logic                   active_o,
  output logic [NUM_PORTS-1:0]   start_o,
  input  logic [2*DataWidth-1:0] result_i,
  input  logic                   done_i,
  output logic                   err_o
);

  mult_arb_state_e         state_q;
  logic [SEL_WIDTH-1:0]    ptr_q;
  logic [SEL_WIDTH-1:0]    sel_q;
  logic [2*DataWidth-1:0]  result_q;
  logic                    pick_found;
  logic [SEL_WIDTH-1:0]    pick_idx;
  logic [NUM_PORTS-1:0]    sel_onehot;
  logic [SEL_WIDTH-1:0]    ptr_next;

  rr_pick #(.N(NUM_PORTS), .W(SEL_WIDTH)) u_pick (
    .req   (req_i),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign ptr_next = (sel_q == SEL_WIDTH'(NUM_PORTS - 1)) ? '0 : sel_q + SEL_WIDTH'(1);

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CntW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CntW-1:0] cnt_q;
  logic            err_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      sel_q    <= '0;
      result_q <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            sel_q   <= pick_idx;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          state_q <= BUSY;
`ifdef MULT_ARB_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        BUSY: begin
          // done_i takes priority over a simultaneous watchdog expiry
          if (done_i) begin
            result_q <= result_i;
            state_q  <= RELEASE;
          end
`ifdef MULT_ARB_TIMEOUT_EN
          else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            err_q   <= 1'b1;
            state_q <= RELEASE;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
`endif
        end
        RELEASE: begin
          ptr_q   <= ptr_next;
          state_q <= IDLE;
`ifdef MULT_ARB_TIMEOUT_EN
          err_q   <= 1'b0;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sel_onehot = NUM_PORTS'(1) << sel_q;
  assign active_o   = (state_q == GRANT) || (state_q == BUSY);
  assign grant_o    = active_o ? sel_onehot : '0;
  assign start_o    = (state_q == GRANT) ? sel_onehot : '0;
  assign done_o     = (state_q == RELEASE) ? sel_onehot : '0;
  assign select_o   = sel_q;
  assign result_o   = result_q;

`ifdef MULT_ARB_TIMEOUT_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed self-checking bench for mult_arbiter (6 ports, 8-bit operands).
module tb_mult_arbiter;
  import mult_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [5:0]  req;
  logic [5:0]  grant;
  logic [5:0]  done;
  logic [15:0] result;
  logic [2:0]  select;
  logic        active;
  logic [5:0]  start;
  logic [15:0] mult_result;
  logic        mult_done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  mult_arbiter #(
    .NUM_PORTS(6),
    .DataWidth(8),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .req_i   (req),
    .grant_o (grant),
    .done_o  (done),
    .result_o(result),
    .select_o(select),
    .active_o(active),
    .start_o (start),
    .result_i(mult_result),
    .done_i  (mult_done),
    .err_o   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Request must already be visible; arbitration happens on the first tick.
  task automatic serve(input int port, input logic [15:0] res, input bit drop);
    logic [5:0] oh;
    oh = 6'(1) << port;
    tick();
    check("grant_in_grant", 32'(grant), 32'(oh));
    check("start_pulse", 32'(start), 32'(oh));
    check("select", 32'(select), 32'(port));
    tick();
    check("start_cleared", 32'(start), 32'd0);
    check("grant_in_busy", 32'(grant), 32'(oh));
    mult_done   = 1'b1;
    mult_result = res;
    tick();
    mult_done = 1'b0;
    check("done_pulse", 32'(done), 32'(oh));
    check("result", 32'(result), 32'(res));
    check("grant_released", 32'(grant), 32'd0);
    check("active_released", 32'(active), 32'd0);
    check("err_quiet", 32'(err), 32'd0);
    if (drop) req[port] = 1'b0;
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    req         = '0;
    mult_result = '0;
    mult_done   = 1'b0;
    #12;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_select", 32'(select), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // single request on port 2, done three cycles after start
    req = 6'b000100;
    tick();
    check("s_grant", 32'(grant), 32'h04);
    check("s_start", 32'(start), 32'h04);
    check("s_select", 32'(select), 32'd2);
    check("s_active", 32'(active), 32'd1);
    tick();
    check("s_start_off", 32'(start), 32'd0);
    tick();
    check("s_busy_grant", 32'(grant), 32'h04);
    mult_done   = 1'b1;
    mult_result = 16'h1234;
    tick();
    mult_done = 1'b0;
    req       = '0;
    check("s_done", 32'(done), 32'h04);
    check("s_result", 32'(result), 32'h1234);
    check("s_active_off", 32'(active), 32'd0);
    tick();
    check("s_idle_done", 32'(done), 32'd0);

    // spurious done in IDLE and GRANT; pointer is now 3 so port 0 wins via wrap
    mult_done   = 1'b1;
    mult_result = 16'h0BAD;
    tick();
    check("sp_idle_active", 32'(active), 32'd0);
    check("sp_idle_done", 32'(done), 32'd0);
    req = 6'b000001;
    tick();
    check("sp_grant", 32'(grant), 32'h01);
    check("sp_done_in_grant", 32'(done), 32'd0);
    tick();
    check("sp_busy_active", 32'(active), 32'd1);
    check("sp_busy_done", 32'(done), 32'd0);
    check("sp_busy_grant", 32'(grant), 32'h01);
    mult_done = 1'b0;
    tick();
    check("sp_still_busy", 32'(active), 32'd1);
    check("sp_result_kept", 32'(result), 32'h1234);
    mult_done   = 1'b1;
    mult_result = 16'hBEEF;
    tick();
    mult_done = 1'b0;
    req       = '0;
    check("sp_real_done", 32'(done), 32'h01);
    check("sp_real_result", 32'(result), 32'hBEEF);
    tick();

    // reset mid-BUSY with pointer at 1; port 3 is aborted
    req = 6'b001000;
    tick();
    check("rb_grant", 32'(grant), 32'h08);
    tick();
    #1 rst_n = 1'b0;
    #1;
    check("rb_grant_clr", 32'(grant), 32'd0);
    check("rb_active_clr", 32'(active), 32'd0);
    check("rb_select_clr", 32'(select), 32'd0);
    check("rb_result_clr", 32'(result), 32'd0);
    req = '0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rb_no_done", 32'(done), 32'd0);
    end
    // pointer back at 0: port 0 ahead of port 5
    req = 6'b100001;
    serve(0, 16'h00AA, 1'b1);
    serve(5, 16'h0055, 1'b1);

    // fairness with every port requesting continuously
    req = 6'b111111;
    for (int p = 0; p < 6; p++) serve(p, 16'(16'h0100 + p), 1'b0);
    serve(0, 16'h0200, 1'b0);
    req = '0;

    // pointer wrap: after port 5, port 0 goes first
    req = 6'b100000;
    serve(5, 16'h0300, 1'b1);
    req = 6'b100001;
    serve(0, 16'h0301, 1'b1);
    serve(5, 16'h0302, 1'b1);
    // sole re-requester is granted again
    req = 6'b100000;
    serve(5, 16'h0303, 1'b1);

`ifdef MULT_ARB_TIMEOUT_EN
    req = 6'b000010;
    tick();
    check("to_grant", 32'(grant), 32'h02);
    req = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_busy", 32'(active), 32'd1);
    end
    tick();
    check("to_done", 32'(done), 32'h02);
    check("to_err", 32'(err), 32'd1);
    check("to_result_kept", 32'(result), 32'h0303);
    tick();
    check("to_err_clr", 32'(err), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
